// File: rtl/sevenseg_time_display.sv
// Multiplexed 4-digit common-anode 7-segment driver for BCD time digits.
// One digit per scan slot; digits are snapshotted at each frame start so a
// frame never mixes old and new time. The colon dp blinks on the idx 2 slot.
module sevenseg_time_display #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode,
  input  logic       blank_lead,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DARK = 7'h7F;
  localparam logic [3:0] AN_DARK  = 4'b1111;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [3:0][3:0]    dig_q, dig_d;
  logic               snap_blank_q, snap_blank_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [3:0]         an_q, an_d;

  // Active-low gfedcba glyph; anything outside 0..9 shows a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Next-state: blink timer, scan timer, frame snapshot and slot outputs.
  always_comb begin
    scan_cnt_d   = scan_cnt_q;
    idx_d        = idx_q;
    blink_cnt_d  = blink_cnt_q;
    blink_ph_d   = blink_ph_q;
    dig_d        = dig_q;
    snap_blank_d = snap_blank_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    an_d         = an_q;

    // The blink timer runs regardless of en so the colon phase stays steady.
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end

    if (!en) begin
      scan_cnt_d = '0;
      idx_d      = 2'd0;
      an_d       = AN_DARK;
      seg_d      = SEG_DARK;
      dp_d       = 1'b1;
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_d = '0;
        idx_d      = idx_q + 2'd1;
      end else begin
        scan_cnt_d = scan_cnt_q + 1'b1;
      end

      if (scan_cnt_q == '0) begin
        // Anti-ghost blank while the anode switches to the next digit.
        an_d  = AN_DARK;
        seg_d = SEG_DARK;
        dp_d  = 1'b1;
        if (idx_q == 2'd0) begin
          snap_blank_d = blank_lead;
          dig_d        = mode ? {m2, m1, s2, s1} : {h2, h1, m2, m1};
        end
      end else if (scan_cnt_q == SCAN_W'(1)) begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = bcd_to_seg(dig_q[idx_q]);
        dp_d  = !((idx_q == 2'd2) && !blink_ph_q);
        if ((idx_q == 2'd3) && snap_blank_q && (dig_q[3] == 4'd0)) begin
          an_d  = AN_DARK;
          seg_d = SEG_DARK;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q   <= '0;
      idx_q        <= 2'd0;
      blink_cnt_q  <= '0;
      blink_ph_q   <= 1'b0;
      dig_q        <= '0;
      snap_blank_q <= 1'b0;
      seg_q        <= SEG_DARK;
      dp_q         <= 1'b1;
      an_q         <= AN_DARK;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      idx_q        <= idx_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_ph_q   <= blink_ph_d;
      dig_q        <= dig_d;
      snap_blank_q <= snap_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_sevenseg_time_display.sv
// Directed bench for sevenseg_time_display with short scan/blink periods.
// Each scenario starts from reset; "edges" counts clock edges since release,
// so slot k's digit is visible after edge 4*k+2 and blanked after edge 4*k+1.
module tb_sevenseg_time_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       blank_lead = 1'b0;
  logic [3:0] s1 = '0, s2 = '0, m1 = '0, m2 = '0, h1 = '0, h2 = '0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int n_vec = 0;
  int n_bad = 0;
  int edges = 0;

  sevenseg_time_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .blank_lead(blank_lead),
    .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (edge %0d)", tag, got, exp, edges);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic run_to(input int n);
    while (edges < n) tick();
  endtask

  task automatic slot(input string tag, input int n, input logic [3:0] e_an,
                      input logic [6:0] e_seg, input logic e_dp);
    run_to(n);
    chk({tag, ".an"}, {4'b0, an}, {4'b0, e_an});
    chk({tag, ".seg"}, {1'b0, seg}, {1'b0, e_seg});
    chk({tag, ".dp"}, {7'b0, dp}, {7'b0, e_dp});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst.an", {4'b0, an}, 8'h0F);
    chk("rst.seg", {1'b0, seg}, 8'h7F);
    chk("rst.dp", {7'b0, dp}, 8'h01);
    tick();
    tick();
    rst = 1'b0;
    edges = 0;
  endtask

  task automatic set_time(input logic [3:0] a2, input logic [3:0] a1, input logic [3:0] b2,
                          input logic [3:0] b1, input logic [3:0] c2, input logic [3:0] c1);
    h2 = a2; h1 = a1; m2 = b2; m1 = b1; s2 = c2; s1 = c1;
  endtask

  initial begin
    // Reset, first lit digit, HH:MM of 12:34:56 and colon blink.
    en = 1'b1; mode = 1'b0; blank_lead = 1'b0;
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    #1;
    do_reset();
    slot("t1.first_blank", 1, 4'b1111, 7'h7F, 1'b1);
    slot("t2.d0", 2, 4'b1110, 7'b0011001, 1'b1);
    slot("t2.d0_hold", 4, 4'b1110, 7'b0011001, 1'b1);
    slot("t2.gap1", 5, 4'b1111, 7'h7F, 1'b1);
    slot("t2.d1", 6, 4'b1101, 7'b0110000, 1'b1);
    slot("t2.gap2", 9, 4'b1111, 7'h7F, 1'b1);
    slot("t2.d2", 10, 4'b1011, 7'b0100100, 1'b0);
    slot("t2.d3", 14, 4'b0111, 7'b1111001, 1'b1);
    slot("t6.blink_off", 26, 4'b1011, 7'b0100100, 1'b1);
    slot("t6.blink_on", 42, 4'b1011, 7'b0100100, 1'b0);

    // MM:SS of 05:59:07.
    mode = 1'b1;
    set_time(4'd0, 4'd5, 4'd5, 4'd9, 4'd0, 4'd7);
    do_reset();
    slot("t3.d0", 2, 4'b1110, 7'b1111000, 1'b1);
    slot("t3.d1", 6, 4'b1101, 7'b1000000, 1'b1);
    slot("t3.d2", 10, 4'b1011, 7'b0010000, 1'b0);
    slot("t3.d3", 14, 4'b0111, 7'b0010010, 1'b1);

    // Leading-zero blanking, released mid-frame.
    mode = 1'b0; blank_lead = 1'b1;
    set_time(4'd0, 4'd9, 4'd3, 4'd4, 4'd0, 4'd0);
    do_reset();
    slot("t4.d2", 10, 4'b1011, 7'b0010000, 1'b0);
    slot("t4.blanked", 14, 4'b1111, 7'h7F, 1'b1);
    blank_lead = 1'b0;
    slot("t4.still_blank", 15, 4'b1111, 7'h7F, 1'b1);
    slot("t4.zero_shown", 30, 4'b0111, 7'b1000000, 1'b1);

    // Invalid BCD dash, corrected mid-frame.
    set_time(4'd1, 4'hC, 4'd3, 4'd4, 4'd0, 4'd0);
    do_reset();
    run_to(3);
    h1 = 4'd5;
    slot("t5.dash", 10, 4'b1011, 7'b0111111, 1'b0);
    slot("t5.fixed", 26, 4'b1011, 7'b0010010, 1'b1);

    // Mid-frame digit change, then en drop and recovery.
    set_time(4'd1, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0);
    do_reset();
    slot("t6.old_m1", 2, 4'b1110, 7'b0110000, 1'b1);
    run_to(6);
    m1 = 4'd8;
    slot("t6.no_tear", 8, 4'b1101, 7'b0110000, 1'b1);
    slot("t6.new_m1", 18, 4'b1110, 7'b0000000, 1'b1);
    run_to(20);
    en = 1'b0;
    slot("t6.en_off", 21, 4'b1111, 7'h7F, 1'b1);
    slot("t6.en_off_hold", 23, 4'b1111, 7'h7F, 1'b1);
    en = 1'b1;
    slot("t6.en_start", 24, 4'b1111, 7'h7F, 1'b1);
    slot("t6.en_first", 25, 4'b1110, 7'b0000000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
